// File: rtl/cpu_pkg.sv
// Shared datapath types and default sizes for the RISC CPU register file.
package cpu_pkg;

  localparam int DATAWIDTH_DEF = 16;
  localparam int REGS_DEF      = 8;
  localparam int ADDRW_DEF     = $clog2(REGS_DEF);

  typedef logic [ADDRW_DEF-1:0]     reg_addr_t;
  typedef logic [DATAWIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: range/zero/bypass select plus optional output register.
module rf_read_port #(
  parameter int DATAWIDTH = 16,
  parameter int REGS      = 8,
  parameter int ADDRW     = 3,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int REG_READ  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 re,
  input  logic [ADDRW-1:0]     raddr,
  input  logic                 wr_en,
  input  logic [ADDRW-1:0]     waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [DATAWIDTH-1:0] mem [REGS],
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rvalid
);

  localparam logic [ADDRW:0] REGS_W = (ADDRW+1)'(REGS);

  logic [DATAWIDTH-1:0] value;

  // wr_en is already qualified as a legal write, so bypass only needs the address match.
  always_comb begin
    value = '0;
    if ({1'b0, raddr} >= REGS_W) begin
      value = '0;
    end else if ((ZERO_REG != 0) && (raddr == '0)) begin
      value = '0;
    end else if ((BYPASS != 0) && wr_en && (waddr == raddr)) begin
      value = wdata;
    end else begin
      value = mem[raddr];
    end
  end

  if (REG_READ != 0) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata  <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= re;
        if (re) begin
          rdata <= value;
        end
      end
    end
  end else begin : g_comb
    logic unused_sigs;
    assign unused_sigs = ^{clk, rst_n};
    assign rdata  = value;
    assign rvalid = re;
  end

endmodule

// File: rtl/reg_file_np.sv
// Multi-read-port register file: one synchronous write port, READ_PORTS read ports.
module reg_file_np
  import cpu_pkg::*;
#(
  parameter  int DATAWIDTH  = DATAWIDTH_DEF,
  parameter  int REGS       = REGS_DEF,
  parameter  int READ_PORTS = 2,
  parameter  int ZERO_REG   = 1,
  parameter  int BYPASS     = 1,
  parameter  int REG_READ   = 0,
  localparam int ADDRW      = $clog2(REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  we,
  input  logic [ADDRW-1:0]                      waddr,
  input  logic [DATAWIDTH-1:0]                  wdata,
  input  logic [READ_PORTS-1:0]                 re,
  input  logic [READ_PORTS-1:0][ADDRW-1:0]      raddr,
  output logic [READ_PORTS-1:0][DATAWIDTH-1:0]  rdata,
  output logic [READ_PORTS-1:0]                 rvalid
);

  localparam logic [ADDRW:0] REGS_W = (ADDRW+1)'(REGS);

  logic [DATAWIDTH-1:0] mem [REGS];
  logic                 wr_legal;
  logic [REGS-1:0]      wsel;

  // Out-of-range addresses and (optionally) register 0 never take a write.
  assign wr_legal = we && ({1'b0, waddr} < REGS_W) &&
                    !((ZERO_REG != 0) && (waddr == '0));

  always_comb begin
    wsel = '0;
    for (int i = 0; i < REGS; i++) begin
      wsel[i] = wr_legal && (waddr == ADDRW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REGS; i++) begin
        if (wsel[i]) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    rf_read_port #(
      .DATAWIDTH (DATAWIDTH),
      .REGS      (REGS),
      .ADDRW     (ADDRW),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS),
      .REG_READ  (REG_READ)
    ) u_port (
      .clk    (clk),
      .rst_n  (rst_n),
      .re     (re[p]),
      .raddr  (raddr[p]),
      .wr_en  (wr_legal),
      .waddr  (waddr),
      .wdata  (wdata),
      .mem    (mem),
      .rdata  (rdata[p]),
      .rvalid (rvalid[p])
    );
  end

endmodule

// File: tb/tb_reg_file_np.sv
// Self-checking bench for reg_file_np across combinational, bypass, registered and range configs.
module tb_reg_file_np;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;

  // Shared stimulus for the four 8-register, 2-port instances.
  logic                 we;
  logic [2:0]           waddr;
  word_t                wdata;
  logic [1:0]           re;
  logic [1:0][2:0]      raddr;

  logic [1:0][15:0] c_rdata, b_rdata, r_rdata, n_rdata;
  logic [1:0]       c_rvalid, b_rvalid, r_rvalid, n_rvalid;

  // Range / multi-port instance: REGS=6, three ports.
  logic             g_we;
  logic [2:0]       g_waddr;
  word_t            g_wdata;
  logic [2:0]       g_re;
  logic [2:0][2:0]  g_raddr;
  logic [2:0][15:0] g_rdata;
  logic [2:0]       g_rvalid;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  word_t m_mem [8];
  word_t exp_rb [2];
  word_t exp_rn [2];

  reg_file_np #(.ZERO_REG(1), .BYPASS(0), .REG_READ(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(c_rdata), .rvalid(c_rvalid));

  reg_file_np #(.ZERO_REG(1), .BYPASS(1), .REG_READ(0)) u_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(b_rdata), .rvalid(b_rvalid));

  reg_file_np #(.ZERO_REG(1), .BYPASS(1), .REG_READ(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(r_rdata), .rvalid(r_rvalid));

  reg_file_np #(.ZERO_REG(1), .BYPASS(0), .REG_READ(1)) u_regnb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(n_rdata), .rvalid(n_rvalid));

  reg_file_np #(.REGS(6), .READ_PORTS(3), .ZERO_REG(1), .BYPASS(0), .REG_READ(0)) u_range (
    .clk(clk), .rst_n(rst_n), .we(g_we), .waddr(g_waddr), .wdata(g_wdata),
    .re(g_re), .raddr(g_raddr), .rdata(g_rdata), .rvalid(g_rvalid));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_pop(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, got, ~got);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  function automatic word_t mread(input logic [2:0] a, input logic w, input logic [2:0] wa,
                                  input word_t wd, input bit byp);
    if (a == 3'd0) return '0;
    if (byp && w && (wa == a)) return wd;
    return m_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      exp_rb[p] = '0;
      exp_rn[p] = '0;
    end
  endtask

  // Driver: called at posedge+1; checks comb outputs mid-cycle, registered ones after the edge.
  task automatic step(input logic w, input logic [2:0] wa, input word_t wd,
                      input logic [1:0] r, input logic [2:0] a0, input logic [2:0] a1);
    word_t      vb [2];
    word_t      vn [2];
    logic [2:0] a  [2];
    a[0] = a0;
    a[1] = a1;
    we = w; waddr = wa; wdata = wd; re = r; raddr[0] = a0; raddr[1] = a1;
    for (int p = 0; p < 2; p++) begin
      vn[p] = mread(a[p], w, wa, wd, 1'b0);
      vb[p] = mread(a[p], w, wa, wd, 1'b1);
    end
    exp_q.push_back({16'h0, vn[0]});
    exp_q.push_back({16'h0, vn[1]});
    exp_q.push_back({30'h0, r});
    exp_q.push_back({16'h0, vb[0]});
    exp_q.push_back({16'h0, vb[1]});
    exp_q.push_back({30'h0, r});
    for (int p = 0; p < 2; p++) begin
      if (r[p]) begin
        exp_rb[p] = vb[p];
        exp_rn[p] = vn[p];
      end
    end
    exp_q.push_back({16'h0, exp_rb[0]});
    exp_q.push_back({16'h0, exp_rb[1]});
    exp_q.push_back({30'h0, r});
    exp_q.push_back({16'h0, exp_rn[0]});
    exp_q.push_back({16'h0, exp_rn[1]});
    exp_q.push_back({30'h0, r});
    #2;
    check_pop("comb_rd0", c_rdata[0]);
    check_pop("comb_rd1", c_rdata[1]);
    check_pop("comb_rv", c_rvalid);
    check_pop("byp_rd0", b_rdata[0]);
    check_pop("byp_rd1", b_rdata[1]);
    check_pop("byp_rv", b_rvalid);
    @(posedge clk);
    if (w && (wa != 3'd0)) m_mem[wa] = wd;
    #1;
    check_pop("reg_rd0", r_rdata[0]);
    check_pop("reg_rd1", r_rdata[1]);
    check_pop("reg_rv", r_rvalid);
    check_pop("regnb_rd0", n_rdata[0]);
    check_pop("regnb_rd1", n_rdata[1]);
    check_pop("regnb_rv", n_rvalid);
  endtask

  task automatic g_cycle(input logic w, input logic [2:0] wa, input word_t wd,
                         input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                         input word_t e0, input word_t e1, input word_t e2);
    g_we = w; g_waddr = wa; g_wdata = wd; g_re = 3'b111;
    g_raddr[0] = a0; g_raddr[1] = a1; g_raddr[2] = a2;
    exp_q.push_back({16'h0, e0});
    exp_q.push_back({16'h0, e1});
    exp_q.push_back({16'h0, e2});
    exp_q.push_back(32'h7);
    #2;
    check_pop("rng_rd0", g_rdata[0]);
    check_pop("rng_rd1", g_rdata[1]);
    check_pop("rng_rd2", g_rdata[2]);
    check_pop("rng_rv", g_rvalid);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       w;
    logic [2:0] wa, a0, a1;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    g_we = 1'b0; g_waddr = '0; g_wdata = '0; g_re = '0; g_raddr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Post-reset contents of r1..r7
    for (int i = 1; i < 8; i++) step(1'b0, 3'd0, 16'h0, 2'b11, 3'(i), 3'(i));

    // Basic write/read and same-cycle old-value read
    step(1'b1, 3'd3, 16'hBEEF, 2'b01, 3'd3, 3'd1);
    step(1'b0, 3'd0, 16'h0,    2'b11, 3'd3, 3'd3);
    step(1'b1, 3'd3, 16'h1234, 2'b11, 3'd3, 3'd3);
    step(1'b0, 3'd0, 16'h0,    2'b11, 3'd3, 3'd0);

    // Bypass on port 1, port 0 on a different register
    step(1'b1, 3'd4, 16'h4444, 2'b00, 3'd0, 3'd0);
    step(1'b1, 3'd5, 16'hA5A5, 2'b11, 3'd4, 3'd5);

    // Zero register, including the would-be bypass cycle
    step(1'b1, 3'd0, 16'hFFFF, 2'b11, 3'd0, 3'd0);
    step(1'b0, 3'd0, 16'h0,    2'b11, 3'd0, 3'd0);

    // Registered read with bypass, then drop re
    step(1'b1, 3'd2, 16'h0042, 2'b01, 3'd2, 3'd0);
    step(1'b0, 3'd0, 16'h0,    2'b00, 3'd2, 3'd0);
    step(1'b0, 3'd0, 16'h0,    2'b10, 3'd7, 3'd2);

    // Random traffic, biased toward read-after-write hits
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      wa = 3'($urandom_range(0, 7));
      a0 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 1) == 0) ? wa : 3'($urandom_range(0, 7));
      step(w, wa, 16'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 3)), a0, a1);
    end

    // Range and multi-port instance
    g_cycle(1'b1, 3'd4, 16'h0C0C, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    g_cycle(1'b1, 3'd7, 16'hBAD1, 3'd7, 3'd1, 3'd4, 16'h0, 16'h0, 16'h0C0C);
    g_cycle(1'b1, 3'd6, 16'hBAD2, 3'd7, 3'd1, 3'd6, 16'h0, 16'h0, 16'h0);
    g_cycle(1'b0, 3'd0, 16'h0,    3'd4, 3'd4, 3'd4, 16'h0C0C, 16'h0C0C, 16'h0C0C);
    g_cycle(1'b0, 3'd0, 16'h0,    3'd1, 3'd0, 3'd5, 16'h0, 16'h0, 16'h0);
    g_cycle(1'b1, 3'd5, 16'h5555, 3'd5, 3'd4, 3'd7, 16'h0, 16'h0C0C, 16'h0);
    g_cycle(1'b0, 3'd0, 16'h0,    3'd5, 3'd7, 3'd6, 16'h5555, 16'h0, 16'h0);

    // Make sure the registered ports hold nonzero data before the reset test
    step(1'b1, 3'd1, 16'h1111, 2'b00, 3'd0, 3'd0);
    step(1'b1, 3'd3, 16'h3333, 2'b11, 3'd1, 3'd3);

    // Asynchronous reset asserted mid-cycle, with a write pending on the held edge
    we = 1'b1; waddr = 3'd6; wdata = 16'h7777; re = 2'b11; raddr[0] = 3'd1; raddr[1] = 3'd3;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 11; i++) exp_q.push_back(32'h0);
    check_pop("rst_comb_rd0", c_rdata[0]);
    check_pop("rst_comb_rd1", c_rdata[1]);
    check_pop("rst_byp_rd0", b_rdata[0]);
    check_pop("rst_byp_rd1", b_rdata[1]);
    check_pop("rst_reg_rd0", r_rdata[0]);
    check_pop("rst_reg_rd1", r_rdata[1]);
    check_pop("rst_reg_rv", r_rvalid);
    check_pop("rst_regnb_rd0", n_rdata[0]);
    check_pop("rst_regnb_rd1", n_rdata[1]);
    check_pop("rst_regnb_rv", n_rvalid);
    check_pop("rst_rng_rd2", g_rdata[2]);
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    check_pop("rst_hold_reg_rv", r_rvalid);
    check_pop("rst_hold_reg_rd0", r_rdata[0]);
    we = 1'b0; re = 2'b00;
    #2 rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;

    // Write during reset must be lost; array cleared
    step(1'b0, 3'd0, 16'h0, 2'b11, 3'd6, 3'd6);
    step(1'b0, 3'd0, 16'h0, 2'b11, 3'd1, 3'd3);
    step(1'b1, 3'd6, 16'h6006, 2'b11, 3'd6, 3'd5);
    step(1'b0, 3'd0, 16'h0, 2'b01, 3'd6, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
